// File: rtl/fib_chk_pkg.sv
// -----------------------------------------------------------------------------
// fib_chk_pkg
// Shared definitions for the Fibonacci run checker:
//   - state_t   : controller states IDLE/HOLD/RUN/SCAN/DRAIN/DONE
//   - DEF_*     : default parameter values used by the interface and top
//   - sat_inc() : saturating increment for counters up to 32 bits wide
// No ports (package).
// -----------------------------------------------------------------------------
package fib_chk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    RUN   = 3'd2,
    SCAN  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_NUM_WORDS    = 10;
  localparam int DEF_BASE_ADDR    = 0;
  localparam int DEF_RESET_CYCLES = 2;
  localparam int DEF_MAX_CYCLES   = 400;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_FIB_A0       = 0;
  localparam int DEF_FIB_A1       = 1;

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/fib_run_checker_if.sv
// -----------------------------------------------------------------------------
// fib_run_checker_if
// Bundles the run-control, memory read port and result signals of the
// Fibonacci run checker.
//   master modport (checker): drives cpu_reset, mem_rd_en, mem_rd_addr, busy,
//     done, pass, timeout, err_count, first_err_idx, cycle_count;
//     receives start, halt, mem_rd_data.
//   slave modport (environment/CPU side): the mirror image.
// -----------------------------------------------------------------------------
interface fib_run_checker_if
  import fib_chk_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              start;
  logic              halt;
  logic              cpu_reset;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [CNT_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_idx;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    input  start, halt, mem_rd_data,
    output cpu_reset, mem_rd_en, mem_rd_addr, busy, done, pass, timeout,
           err_count, first_err_idx, cycle_count
  );

  modport slave (
    output start, halt, mem_rd_data,
    input  cpu_reset, mem_rd_en, mem_rd_addr, busy, done, pass, timeout,
           err_count, first_err_idx, cycle_count
  );
endinterface

// File: rtl/fib_seq_gen.sv
// -----------------------------------------------------------------------------
// fib_seq_gen
// Expected-value generator: value = exp(k), where exp(0)=FIB_A0,
// exp(1)=FIB_A1, exp(k)=exp(k-1)+exp(k-2) mod 2^DATA_W.
// Ports:
//   clk   in  clock
//   reset in  synchronous active-high, same effect as load
//   load  in  restart the sequence at exp(0)
//   step  in  advance to the next term
//   value out current term
// -----------------------------------------------------------------------------
module fib_seq_gen #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] FIB_A0 = '0,
  parameter logic [DATA_W-1:0] FIB_A1 = {{(DATA_W-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] value
);
  logic [DATA_W-1:0] r_cur;
  logic [DATA_W-1:0] r_nxt;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      r_cur <= FIB_A0;
      r_nxt <= FIB_A1;
    end else if (step) begin
      r_cur <= r_nxt;
      r_nxt <= r_cur + r_nxt;
    end
  end

  assign value = r_cur;
endmodule

// File: rtl/fib_run_checker.sv
// -----------------------------------------------------------------------------
// fib_run_checker
// Holds the CPU in reset, lets it run until halt or a cycle budget expires,
// then scans NUM_WORDS data-memory words from BASE_ADDR and compares each
// against a Fibonacci reference, reporting pass/fail.
// Ports:
//   clk   in  clock, rising edge
//   reset in  synchronous active-high reset
//   bus   master modport of fib_run_checker_if (start, halt, cpu_reset,
//         mem read port, busy/done/pass/timeout, err_count, first_err_idx,
//         cycle_count)
// Optional build macro: FIB_CHK_STOP_ON_ERR_EN -- when defined, the first
// mismatch aborts the scan (no further reads, err_count=1, DONE next cycle).
// -----------------------------------------------------------------------------
module fib_run_checker
  import fib_chk_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int NUM_WORDS    = DEF_NUM_WORDS,
  parameter int BASE_ADDR    = DEF_BASE_ADDR,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int FIB_A0       = DEF_FIB_A0,
  parameter int FIB_A1       = DEF_FIB_A1
) (
  input  logic               clk,
  input  logic               reset,
  fib_run_checker_if.master  bus
);
  localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W:0]    BUDGET    = (CNT_W+1)'(MAX_CYCLES);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [CNT_W-1:0]  r_err_count;
  logic [ADDR_W-1:0] r_first_err_idx;
  logic              r_timeout;
  logic [ADDR_W:0]   r_scan_idx;
  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_idx_p1;

  logic [DATA_W-1:0] w_exp;
  logic              w_mismatch;
  logic              w_abort;
  logic              w_rd_en;
  logic              w_last_issue;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_budget_hit;
  logic              w_seq_load;

  assign w_mismatch   = r_vld_p1 && (bus.mem_rd_data != w_exp);
`ifdef FIB_CHK_STOP_ON_ERR_EN
  assign w_abort      = w_mismatch;
`else
  assign w_abort      = 1'b0;
`endif
  // An aborting compare also suppresses the read issued in the same cycle.
  assign w_rd_en      = (r_state == SCAN) && !w_abort;
  assign w_last_issue = (r_scan_idx == LAST_IDX);
  assign w_cnt_nxt    = CNT_W'(sat_inc(32'(r_cycle_count), CNT_W));
  assign w_budget_hit = ({1'b0, w_cnt_nxt} >= BUDGET);
  assign w_seq_load   = (r_state != SCAN) && (r_state != DRAIN);

  fib_seq_gen #(
    .DATA_W (DATA_W),
    .FIB_A0 (DATA_W'(FIB_A0)),
    .FIB_A1 (DATA_W'(FIB_A1))
  ) u_seq (
    .clk   (clk),
    .reset (reset),
    .load  (w_seq_load),
    .step  (r_vld_p1),
    .value (w_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (bus.start) w_state_nxt = HOLD;
      HOLD:       if (r_hold_cnt >= HOLD_LAST) w_state_nxt = RUN;
      RUN:        if (bus.halt || w_budget_hit) w_state_nxt = SCAN;
      SCAN: begin
        if (w_abort)           w_state_nxt = DONE;
        else if (w_last_issue) w_state_nxt = DRAIN;
      end
      DRAIN:      w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: read issue / run control ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt      <= '0;
      r_cycle_count   <= '0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_timeout       <= 1'b0;
      r_scan_idx      <= '0;
      r_vld_p1        <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_en;
      unique case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_hold_cnt      <= '0;
            r_cycle_count   <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_timeout       <= 1'b0;
            r_scan_idx      <= '0;
          end
        end
        HOLD: r_hold_cnt <= r_hold_cnt + CNT_ONE;
        RUN: begin
          r_cycle_count <= w_cnt_nxt;
          // halt wins over a budget expiry in the same cycle
          if (!bus.halt && w_budget_hit) r_timeout <= 1'b1;
        end
        SCAN: if (w_rd_en) r_scan_idx <= r_scan_idx + IDX_ONE;
        default: ;
      endcase
      // ---- stage p1: compare returned word ----
      if (w_mismatch) begin
        r_err_count <= CNT_W'(sat_inc(32'(r_err_count), CNT_W));
        if (r_err_count == '0) r_first_err_idx <= r_idx_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_idx_p1 <= r_scan_idx[ADDR_W-1:0];
  end

  assign bus.cpu_reset     = reset || (r_state != RUN);
  assign bus.mem_rd_en     = w_rd_en;
  assign bus.mem_rd_addr   = (r_state == SCAN) ? (BASE + r_scan_idx[ADDR_W-1:0]) : '0;
  assign bus.busy          = (r_state != IDLE) && (r_state != DONE);
  assign bus.done          = (r_state == DONE);
  assign bus.pass          = (r_state == DONE) && (r_err_count == '0) && !r_timeout;
  assign bus.timeout       = r_timeout;
  assign bus.err_count     = r_err_count;
  assign bus.first_err_idx = r_first_err_idx;
  assign bus.cycle_count   = r_cycle_count;
endmodule

// File: tb/tb_fib_run_checker.sv
module tb_fib_run_checker;
`ifdef FIB_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  localparam int N1 = 10, B1 = 0, MAXC = 400;
  localparam int N2 = 16, B2 = 250;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fib_run_checker_if #(.DATA_W(32), .ADDR_W(8), .CNT_W(16)) b1 ();
  fib_run_checker_if #(.DATA_W(8),  .ADDR_W(8), .CNT_W(16)) b2 ();

  fib_run_checker #(.DATA_W(32), .ADDR_W(8), .NUM_WORDS(N1), .BASE_ADDR(B1),
                    .RESET_CYCLES(2), .MAX_CYCLES(MAXC), .CNT_W(16)) dut1 (
    .clk(clk), .reset(rst), .bus(b1));
  fib_run_checker #(.DATA_W(8), .ADDR_W(8), .NUM_WORDS(N2), .BASE_ADDR(B2),
                    .RESET_CYCLES(2), .MAX_CYCLES(MAXC), .CNT_W(16)) dut2 (
    .clk(clk), .reset(rst), .bus(b2));

  int checks = 0;
  int failures = 0;
  logic [31:0] mem1 [256];
  logic [7:0]  mem2 [256];
  logic [7:0]  rd_q1 [$];
  logic [7:0]  rd_q2 [$];

  // Memory models: registered read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (b1.mem_rd_en) begin
      b1.mem_rd_data <= mem1[b1.mem_rd_addr];
      rd_q1.push_back(b1.mem_rd_addr);
    end
    if (b2.mem_rd_en) begin
      b2.mem_rd_data <= mem2[b2.mem_rd_addr];
      rd_q2.push_back(b2.mem_rd_addr);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fibonacci term k modulo 2^w, from plain arithmetic.
  function automatic logic [31:0] fib_ref(input int k, input int w);
    longint unsigned a, b, t, mask;
    mask = (64'd1 << w) - 64'd1;
    a = 0; b = 1;
    for (int i = 0; i < k; i++) begin
      t = (a + b) & mask; a = b; b = t;
    end
    return 32'(a);
  endfunction

  task automatic fill1();
    for (int i = 0; i < 256; i++) mem1[i] = $urandom;
    for (int k = 0; k < N1; k++) mem1[(B1 + k) % 256] = fib_ref(k, 32);
  endtask

  task automatic fill2();
    for (int i = 0; i < 256; i++) mem2[i] = 8'($urandom);
    for (int k = 0; k < N2; k++) mem2[(B2 + k) % 256] = 8'(fib_ref(k, 8));
  endtask

  task automatic check_reset1(input string tag);
    check({tag, "_cpu_reset"}, b1.cpu_reset, 1);
    check({tag, "_rd_en"}, b1.mem_rd_en, 0);
    check({tag, "_rd_addr"}, b1.mem_rd_addr, 0);
    check({tag, "_busy"}, b1.busy, 0);
    check({tag, "_done"}, b1.done, 0);
    check({tag, "_pass"}, b1.pass, 0);
    check({tag, "_timeout"}, b1.timeout, 0);
    check({tag, "_err"}, b1.err_count, 0);
    check({tag, "_first"}, b1.first_err_idx, 0);
    check({tag, "_cycles"}, b1.cycle_count, 0);
  endtask

  // One complete run on DUT1; halt_at==0 means never halt.
  task automatic run1(input string tag, input int halt_at, input bit poke);
    int n, err, first, reads, lat, bad;
    err = 0; first = 0;
    for (int k = 0; k < N1; k++)
      if (mem1[(B1 + k) % 256] != fib_ref(k, 32)) begin
        if (err == 0) first = k;
        err++;
      end
    if (STOP && err > 0) begin
      err = 1; reads = first + 1; lat = first + 2;
    end else begin
      reads = N1; lat = N1 + 1;
    end
    rd_q1.delete();
    b1.start = 1'b1; tick(); b1.start = 1'b0;
    n = 0;
    while (b1.cpu_reset && n < 50) begin n++; tick(); end
    check({tag, "_hold_cycles"}, n, 2);
    if (halt_at > 0) begin
      for (int c = 1; c < halt_at; c++) begin
        if (poke && c == halt_at / 2) b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
      end
      b1.halt = 1'b1; tick(); b1.halt = 1'b0;
    end
    n = 0;
    while (!b1.done && n < 2000) begin n++; tick(); end
    check({tag, "_done_latency"}, n, (halt_at > 0) ? lat : (MAXC + lat));
    check({tag, "_done"}, b1.done, 1);
    check({tag, "_busy"}, b1.busy, 0);
    check({tag, "_cycles"}, b1.cycle_count, (halt_at > 0) ? halt_at : MAXC);
    check({tag, "_timeout"}, b1.timeout, (halt_at > 0) ? 0 : 1);
    check({tag, "_err"}, b1.err_count, err);
    check({tag, "_first"}, b1.first_err_idx, first);
    check({tag, "_pass"}, b1.pass, ((err == 0) && (halt_at > 0)) ? 1 : 0);
    check({tag, "_reads"}, rd_q1.size(), reads);
    bad = -1;
    for (int i = 0; i < rd_q1.size(); i++)
      if (bad < 0 && rd_q1[i] != 8'((B1 + i) % 256)) bad = i;
    check({tag, "_rd_addr_seq"}, bad, -1);
  endtask

  task automatic run2(input string tag, input int halt_at);
    int n, err, first, bad;
    err = 0; first = 0;
    for (int k = 0; k < N2; k++)
      if (mem2[(B2 + k) % 256] != 8'(fib_ref(k, 8))) begin
        if (err == 0) first = k;
        err++;
      end
    if (STOP && err > 0) err = 1;
    rd_q2.delete();
    b2.start = 1'b1; tick(); b2.start = 1'b0;
    n = 0;
    while (b2.cpu_reset && n < 50) begin n++; tick(); end
    for (int c = 1; c < halt_at; c++) tick();
    b2.halt = 1'b1; tick(); b2.halt = 1'b0;
    n = 0;
    while (!b2.done && n < 2000) begin n++; tick(); end
    check({tag, "_done"}, b2.done, 1);
    check({tag, "_err"}, b2.err_count, err);
    check({tag, "_first"}, b2.first_err_idx, first);
    check({tag, "_pass"}, b2.pass, (err == 0) ? 1 : 0);
    bad = -1;
    for (int i = 0; i < rd_q2.size(); i++)
      if (bad < 0 && rd_q2[i] != 8'((B2 + i) % 256)) bad = i;
    check({tag, "_rd_addr_seq"}, bad, -1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    b1.start = 1'b0; b1.halt = 1'b0;
    b2.start = 1'b0; b2.halt = 1'b0;
    fill1(); fill2();
    tick(); tick();
    check_reset1("reset");
    rst = 1'b0;
    tick();

    fill1();
    run1("good_h60", 60, 1'b0);

    mem1[6] = 32'd9;
    run1("bad6_h60", 60, 1'b0);

    fill1();
    run1("timeout", 0, 1'b0);

    for (int it = 0; it < 4; it++) begin
      int ncor;
      fill1();
      ncor = $urandom_range(0, 3);
      for (int j = 0; j < ncor; j++)
        mem1[(B1 + $urandom_range(0, N1 - 1)) % 256] ^= ($urandom | 32'd1);
      run1($sformatf("rand%0d", it), $urandom_range(1, 350), 1'b1);
    end

    // Reset in the middle of the scan, then a clean run.
    fill1();
    b1.start = 1'b1; tick(); b1.start = 1'b0;
    n = 0;
    while (b1.cpu_reset && n < 50) begin n++; tick(); end
    for (int c = 1; c < 20; c++) tick();
    b1.halt = 1'b1; tick(); b1.halt = 1'b0;
    tick(); tick(); tick();
    check("midscan_busy", b1.busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset1("midscan_rst");
    tick();
    run1("after_rst", 45, 1'b0);

    // 8-bit wrap arithmetic and address wrap past 255.
    fill2();
    run2("w8_good", 30);
    mem2[(B2 + 15) % 256] ^= 8'h40;
    run2("w8_bad15", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fib_run_checker.md
Name: fib_run_checker

Overview:
Synthesizable run controller and self-checker for the single_cycle CPU running the Fibonacci program. It holds the CPU in reset, then lets it run for a bounded cycle budget or until halt is flagged. It then scans a parametrised window of data memory through a read port and compares each word against an on-the-fly Fibonacci reference. It replaces the fixed 100-cycle, 10-word dump with a parametrised pass/fail result usable on FPGA or in regression.

Parameters:
DATA_W, 32, data memory word width; reference arithmetic is modulo 2^DATA_W
ADDR_W, 8, data memory word-address width
NUM_WORDS, 10, words checked, starting at BASE_ADDR (1..2^ADDR_W)
BASE_ADDR, 0, first word address scanned
RESET_CYCLES, 2, cycles cpu_reset is held high after start
MAX_CYCLES, 400, run budget in cycles after cpu_reset deasserts
CNT_W, 16, width of cycle_count and err_count
FIB_A0, 0, expected value of word 0
FIB_A1, 1, expected value of word 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when in IDLE or DONE
halt  in  1  CPU halt indication; ends RUN early
cpu_reset  out  1  reset driven to the CPU
mem_rd_en  out  1  data memory read strobe
mem_rd_addr  out  ADDR_W  data memory word address
mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
pass  out  1  valid when done; 1 iff err_count==0 and timeout==0
timeout  out  1  budget exhausted without halt (informational; counts as fail)
err_count  out  CNT_W  mismatching words, saturating
first_err_idx  out  ADDR_W  index (relative to BASE_ADDR) of the first mismatch
cycle_count  out  CNT_W  RUN cycles elapsed, saturating

Behaviour:
- Reset values: cpu_reset=1, mem_rd_en=0, mem_rd_addr=0, busy=0, done=0, pass=0, timeout=0, err_count=0, first_err_idx=0, cycle_count=0; state=IDLE.
- cpu_reset is 1 in every state except RUN.
- IDLE: wait for start. On start: clear all result outputs, go to HOLD.
- HOLD: hold cpu_reset=1 for exactly RESET_CYCLES cycles, then go to RUN.
- RUN: cpu_reset=0. cycle_count increments every cycle.
  - halt high: go to SCAN the next cycle.
  - cycle_count reaching MAX_CYCLES with no halt: set timeout=1, go to SCAN.
  - halt and budget expiry in the same cycle: halt wins; timeout stays 0.
- SCAN: issue NUM_WORDS back-to-back reads, one per cycle, addresses BASE_ADDR..BASE_ADDR+NUM_WORDS-1. Address arithmetic wraps modulo 2^ADDR_W.
  - Compare is pipelined: the word returned in cycle k+1 is compared with the expected value for index k.
  - After the last issue, go to DRAIN.
- DRAIN: one cycle to compare the final word, then go to DONE.
- Reference generator: exp0=FIB_A0, exp1=FIB_A1, exp(k)=exp(k-1)+exp(k-2) mod 2^DATA_W. It advances once per compare.
- Mismatch handling: err_count increments (saturating at all-ones). first_err_idx is captured on the first mismatch only.
- DONE: done=1; pass=(err_count==0)&&!timeout. Results hold until the next start, which restarts from HOLD.
- start while busy is ignored.
- reset in any state returns to IDLE with reset values within one cycle; cpu_reset is reasserted in that same cycle.
- NUM_WORDS==1: a single read, no recurrence step.
- Scan latency: NUM_WORDS+1 cycles from SCAN entry to DONE.

Optional Feature:
FIB_CHK_STOP_ON_ERR_EN
- Defined: the first mismatch aborts SCAN. No further reads are issued, err_count=1, and DONE is entered the next cycle.
- Undefined: the full window is always scanned and all mismatches are counted.

Decomposition:
- Package fib_chk_pkg holds:
  - the state enum IDLE/HOLD/RUN/SCAN/DRAIN/DONE;
  - default parameter constants;
  - a saturating-increment function.
- Sub-module fib_seq_gen (DATA_W; ports clk, reset, load, step, value) produces the expected sequence. The top contains the FSM, counters and compare.

Test Plan:
- Correct memory model (mem[i]=Fib(i): 0,1,1,2,3,5,8,13,21,34), halt at cycle 60 -> done, pass=1, err_count=0, timeout=0, cycle_count=60.
- Same model with mem[6]=9 -> pass=0, err_count=1, first_err_idx=6; with FIB_CHK_STOP_ON_ERR_EN, no mem_rd_en after address 6.
- halt never asserted, MAX_CYCLES=400 -> timeout=1, cycle_count=400, scan still runs, pass=0.
- DATA_W=8, NUM_WORDS=16 with memory holding Fib mod 256 (mem[14]=121, mem[15]=98) -> pass=1, confirming wrap arithmetic.
- reset pulsed mid-SCAN -> next cycle IDLE, cpu_reset=1, all outputs at reset values; a later start completes normally.
- start pulsed during RUN -> ignored; cycle_count continues uninterrupted.
